// File: rtl/hrange_arbiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hrange_arbiter_pkg                                                       |
// | Shared types for the two-requester hrange arbiter.                       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package hrange_arbiter_pkg;

    // The argument bundle is sized by this constant; the arbiter's WIDTH follows it.
    localparam int c_ARG_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_STREAM = 2'd2
    } state_t;

    typedef logic req_idx_t;

    typedef struct packed {
        logic signed [c_ARG_WIDTH-1:0] base;
        logic signed [c_ARG_WIDTH-1:0] limit;
        logic signed [c_ARG_WIDTH-1:0] step;
    } args_t;

endpackage
`default_nettype wire

// File: rtl/hrange.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hrange                                                                   |
// | Range generator: emits (v, v) for v = base, base+step, ... up to limit.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module hrange #(
    parameter int WIDTH = 32
) (
    input  logic                    _clock,
    input  logic                    _reset,
    input  logic                    _start,
    input  logic signed [WIDTH-1:0] base,
    input  logic signed [WIDTH-1:0] limit,
    input  logic signed [WIDTH-1:0] step,
    input  logic                    _ready,
    output logic                    _valid,
    output logic signed [WIDTH-1:0] _out0,
    output logic signed [WIDTH-1:0] _out1,
    output logic                    _done
);

    logic signed [WIDTH-1:0] r_cur;
    logic signed [WIDTH-1:0] r_limit;
    logic signed [WIDTH-1:0] r_step;
    logic                    r_running;

    logic signed [WIDTH:0]   w_sum;
    logic                    w_overflow;
    logic                    w_in_range;

    assign w_sum      = {r_cur[WIDTH-1], r_cur} + {r_step[WIDTH-1], r_step};
    assign w_overflow = (w_sum[WIDTH] != w_sum[WIDTH-1]);

    // A zero step is treated as an empty range rather than an endless stream.
    always_comb begin
        w_in_range = 1'b0;
        if (r_running) begin
            if (!r_step[WIDTH-1] && (r_step != '0)) begin
                w_in_range = (r_cur < r_limit);
            end else if (r_step[WIDTH-1]) begin
                w_in_range = (r_cur > r_limit);
            end
        end
    end

    always_ff @(posedge _clock) begin
        if (_reset) begin
            r_running <= 1'b0;
            r_cur     <= '0;
            r_limit   <= '0;
            r_step    <= '0;
        end else if (_start) begin
            r_running <= 1'b1;
            r_cur     <= base;
            r_limit   <= limit;
            r_step    <= step;
        end else if (w_in_range && _ready) begin
            if (w_overflow) begin
                r_running <= 1'b0;
            end else begin
                r_cur <= w_sum[WIDTH-1:0];
            end
        end
    end

    assign _valid = w_in_range;
    assign _out0  = r_cur;
    assign _out1  = r_cur;
    assign _done  = !w_in_range;

endmodule
`default_nettype wire

// File: rtl/hrange_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hrange_arbiter                                                           |
// | Round-robin sharing of one hrange generator between two requesters.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module hrange_arbiter
    import hrange_arbiter_pkg::*;
#(
    parameter int WIDTH = c_ARG_WIDTH
) (
    input  logic                    _clock,
    input  logic                    _reset,
    input  logic                    req0_start,
    input  logic signed [WIDTH-1:0] req0_base,
    input  logic signed [WIDTH-1:0] req0_limit,
    input  logic signed [WIDTH-1:0] req0_step,
    input  logic                    req0_ready,
    output logic                    req0_valid,
    output logic signed [WIDTH-1:0] req0_out0,
    output logic signed [WIDTH-1:0] req0_out1,
    output logic                    req0_done,
    output logic                    req0_busy,
    input  logic                    req1_start,
    input  logic signed [WIDTH-1:0] req1_base,
    input  logic signed [WIDTH-1:0] req1_limit,
    input  logic signed [WIDTH-1:0] req1_step,
    input  logic                    req1_ready,
    output logic                    req1_valid,
    output logic signed [WIDTH-1:0] req1_out0,
    output logic signed [WIDTH-1:0] req1_out1,
    output logic                    req1_done,
    output logic                    req1_busy
);

    logic [1:0]              w_start;
    logic [1:0]              w_ready;
    logic [1:0]              w_pending;
    logic [1:0]              w_clear;
    logic [1:0]              w_route;
    args_t                   w_req_args  [2];
    args_t                   w_slot_args [2];
    args_t                   w_launch_args;

    state_t                  r_state;
    state_t                  w_state_next;
    req_idx_t                r_prio;
    req_idx_t                r_grant;
    req_idx_t                w_pick;
    logic                    w_any_pending;

    logic                    w_inner_start;
    logic                    w_inner_ready;
    logic                    w_inner_valid;
    logic                    w_inner_done;
    logic signed [WIDTH-1:0] w_inner_out0;
    logic signed [WIDTH-1:0] w_inner_out1;

    assign w_start        = {req1_start, req0_start};
    assign w_ready        = {req1_ready, req0_ready};
    assign w_req_args[0]  = '{base: req0_base, limit: req0_limit, step: req0_step};
    assign w_req_args[1]  = '{base: req1_base, limit: req1_limit, step: req1_step};

    // Per-requester pending register; a start while busy is dropped.
    generate
        for (genvar g = 0; g < 2; g++) begin : g_slot
            logic  r_pending;
            args_t r_args;

            always_ff @(posedge _clock) begin
                if (_reset) begin
                    r_pending <= 1'b0;
                    r_args    <= '0;
                end else if (w_clear[g]) begin
                    r_pending <= 1'b0;
                end else if (w_start[g] && !r_pending) begin
                    r_pending <= 1'b1;
                    r_args    <= w_req_args[g];
                end
            end

            assign w_pending[g]   = r_pending;
            assign w_slot_args[g] = r_args;
        end
    endgenerate

    assign w_any_pending = |w_pending;
    assign w_pick        = w_pending[r_prio] ? r_prio : ~r_prio;
    assign w_launch_args = w_slot_args[w_pick];

    always_comb begin
        w_state_next  = r_state;
        w_inner_start = 1'b0;
        w_inner_ready = 1'b0;
        w_clear       = 2'b00;
        case (r_state)
            ST_IDLE: begin
                if (w_any_pending) begin
                    w_inner_start = 1'b1;
                    w_state_next  = ST_LAUNCH;
                end
            end
            // Idle cycle so the previous call's done level is never sampled.
            ST_LAUNCH: begin
                w_state_next = ST_STREAM;
            end
            ST_STREAM: begin
                w_inner_ready = w_ready[r_grant];
                if (w_inner_done && !w_inner_valid) begin
                    w_clear[r_grant] = 1'b1;
                    w_state_next     = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge _clock) begin
        if (_reset) begin
            r_state <= ST_IDLE;
            r_prio  <= 1'b0;
            r_grant <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if ((r_state == ST_IDLE) && w_any_pending) begin
                r_grant <= w_pick;
            end
            if (|w_clear) begin
                r_prio <= ~r_grant;
            end
        end
    end

    hrange #(
        .WIDTH (WIDTH)
    ) _inst (
        ._clock (_clock),
        ._reset (_reset),
        ._start (w_inner_start),
        .base   (w_launch_args.base),
        .limit  (w_launch_args.limit),
        .step   (w_launch_args.step),
        ._ready (w_inner_ready),
        ._valid (w_inner_valid),
        ._out0  (w_inner_out0),
        ._out1  (w_inner_out1),
        ._done  (w_inner_done)
    );

    assign w_route[0] = (r_state == ST_STREAM) && (r_grant == 1'b0);
    assign w_route[1] = (r_state == ST_STREAM) && (r_grant == 1'b1);

    assign req0_valid = w_route[0] && w_inner_valid;
    assign req0_out0  = w_route[0] ? w_inner_out0 : '0;
    assign req0_out1  = w_route[0] ? w_inner_out1 : '0;
    assign req0_done  = w_clear[0];
    assign req0_busy  = w_pending[0];

    assign req1_valid = w_route[1] && w_inner_valid;
    assign req1_out0  = w_route[1] ? w_inner_out0 : '0;
    assign req1_out1  = w_route[1] ? w_inner_out1 : '0;
    assign req1_done  = w_clear[1];
    assign req1_busy  = w_pending[1];

endmodule
`default_nettype wire

// File: tb/tb_hrange_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_hrange_arbiter                                                        |
// | Table-driven and sequence checks with a per-requester scoreboard.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_hrange_arbiter;

    logic               _clock = 1'b0;
    logic               _reset = 1'b1;
    logic               req0_start = 1'b0, req1_start = 1'b0;
    logic               req0_ready = 1'b0, req1_ready = 1'b0;
    logic signed [31:0] req0_base = '0, req0_limit = '0, req0_step = '0;
    logic signed [31:0] req1_base = '0, req1_limit = '0, req1_step = '0;
    logic               req0_valid, req1_valid, req0_done, req1_done, req0_busy, req1_busy;
    logic signed [31:0] req0_out0, req0_out1, req1_out0, req1_out1;

    hrange_arbiter #(.WIDTH(32)) dut (
        ._clock(_clock), ._reset(_reset),
        .req0_start(req0_start), .req0_base(req0_base), .req0_limit(req0_limit),
        .req0_step(req0_step), .req0_ready(req0_ready), .req0_valid(req0_valid),
        .req0_out0(req0_out0), .req0_out1(req0_out1), .req0_done(req0_done),
        .req0_busy(req0_busy),
        .req1_start(req1_start), .req1_base(req1_base), .req1_limit(req1_limit),
        .req1_step(req1_step), .req1_ready(req1_ready), .req1_valid(req1_valid),
        .req1_out0(req1_out0), .req1_out1(req1_out1), .req1_done(req1_done),
        .req1_busy(req1_busy)
    );

    always #5 _clock = ~_clock;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int exp0[$];
    int exp1[$];
    int got0, got1, done0, done1;
    int t_first0, t_first1, t_done0, t_done1, t_start;
    bit pv0 = 0, pr0 = 0, pv1 = 0, pr1 = 0, prst = 1;
    int po0 = 0, po1 = 0;
    int n;
    bit busy_drop;

    typedef struct {
        bit who;
        int base;
        int limit;
        int step;
        int n_exp;
        int budget;
    } vec_t;
    vec_t tbl[6];
    bit   bp_pat[4];

    always @(posedge _clock) cyc++;

    task automatic check(input string nm, input longint got, input longint want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, got, want);
        end
    endtask

    // Scoreboard consumer: pops an expected value for every accepted tuple.
    always @(negedge _clock) begin
        if (req0_valid && req0_ready) begin
            if (exp0.size() == 0) begin
                checks++; errors++;
                $display("FAIL req0_unexpected: got tuple %0d with nothing expected", req0_out0);
            end else begin
                int e;
                e = exp0.pop_front();
                check("req0_out0", req0_out0, e);
                check("req0_out1", req0_out1, e);
            end
            if (t_first0 < 0) t_first0 = cyc;
            got0++;
        end
        if (req1_valid && req1_ready) begin
            if (exp1.size() == 0) begin
                checks++; errors++;
                $display("FAIL req1_unexpected: got tuple %0d with nothing expected", req1_out0);
            end else begin
                int e;
                e = exp1.pop_front();
                check("req1_out0", req1_out0, e);
                check("req1_out1", req1_out1, e);
            end
            if (t_first1 < 0) t_first1 = cyc;
            got1++;
        end
        if (req0_done) begin
            done0++; t_done0 = cyc;
            check("req0_done_drained", exp0.size(), 0);
        end
        if (req1_done) begin
            done1++; t_done1 = cyc;
            check("req1_done_drained", exp1.size(), 0);
        end
        if (pv0 && !pr0 && !prst) begin
            check("req0_hold_valid", req0_valid, 1);
            check("req0_hold_data", req0_out0, po0);
        end
        if (pv1 && !pr1 && !prst) begin
            check("req1_hold_valid", req1_valid, 1);
            check("req1_hold_data", req1_out0, po1);
        end
        pv0 = req0_valid; pr0 = req0_ready; po0 = req0_out0;
        pv1 = req1_valid; pr1 = req1_ready; po1 = req1_out0;
        prst = _reset;
    end

    task automatic tick();
        @(posedge _clock);
        #1;
    endtask

    task automatic clear_counts();
        got0 = 0; got1 = 0; done0 = 0; done1 = 0;
        t_first0 = -1; t_first1 = -1; t_done0 = -1; t_done1 = -1;
    endtask

    function automatic void push_range(input bit who, input int b, input int l, input int s);
        if (s > 0) begin
            for (int v = b; v < l; v += s) if (who) exp1.push_back(v); else exp0.push_back(v);
        end else if (s < 0) begin
            for (int v = b; v > l; v += s) if (who) exp1.push_back(v); else exp0.push_back(v);
        end
    endfunction

    task automatic set_req(input bit who, input int b, input int l, input int s);
        if (who) begin
            req1_start = 1'b1; req1_base = b; req1_limit = l; req1_step = s;
        end else begin
            req0_start = 1'b1; req0_base = b; req0_limit = l; req0_step = s;
        end
    endtask

    task automatic launch(input bit who, input int b, input int l, input int s);
        set_req(who, b, l, s);
        push_range(who, b, l, s);
        t_start = cyc;
        tick();
        req0_start = 1'b0;
        req1_start = 1'b0;
    endtask

    task automatic wait_done(input bit who, input int budget, input string nm);
        int k;
        k = 0;
        while (((who ? done1 : done0) < 1) && (k < budget)) begin
            tick();
            k++;
        end
        check(nm, who ? done1 : done0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{1'b0,  0, 10,  2, 5, 20};
        tbl[1] = '{1'b0, 10,  0, -3, 4, 20};
        tbl[2] = '{1'b1,  0,  4,  1, 4, 20};
        tbl[3] = '{1'b0,  3,  2,  1, 0,  6};
        tbl[4] = '{1'b1, -5, -1,  2, 2, 20};
        tbl[5] = '{1'b1,  5,  5,  1, 0,  6};
        bp_pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        clear_counts();

        repeat (3) tick();
        check("rst_valid0", req0_valid, 0);
        check("rst_valid1", req1_valid, 0);
        check("rst_busy0", req0_busy, 0);
        check("rst_busy1", req1_busy, 0);
        check("rst_done0", req0_done, 0);
        check("rst_out1_1", req1_out1, 0);
        _reset = 1'b0;
        req0_ready = 1'b1;
        req1_ready = 1'b1;
        tick();

        // Single calls, one requester at a time.
        for (int i = 0; i < 6; i++) begin
            clear_counts();
            launch(tbl[i].who, tbl[i].base, tbl[i].limit, tbl[i].step);
            check("tbl_busy_set", tbl[i].who ? req1_busy : req0_busy, 1);
            wait_done(tbl[i].who, tbl[i].budget, "tbl_done");
            check("tbl_count", tbl[i].who ? got1 : got0, tbl[i].n_exp);
            check("tbl_other_count", tbl[i].who ? got0 : got1, 0);
            check("tbl_busy_clear", tbl[i].who ? req1_busy : req0_busy, 0);
            if (i == 0) check("launch_latency", t_first0 - t_start, 3);
            if (i == 5) check("empty_done_latency", t_done1 - t_start, 3);
        end

        // Simultaneous starts: requester 0 holds priority.
        clear_counts();
        set_req(1'b0, 1, 11, 3);
        push_range(1'b0, 1, 11, 3);
        launch(1'b1, 0, 10, 2);
        n = 0;
        busy_drop = 1'b0;
        while (done1 < 1 && n < 80) begin
            if (!req1_busy) busy_drop = 1'b1;
            tick();
            n++;
        end
        check("sim_done0", done0, 1);
        check("sim_done1", done1, 1);
        check("sim_busy1_held", busy_drop, 0);
        check("sim_order", t_done0 < t_first1, 1);
        check("sim_count0", got0, 4);
        check("sim_count1", got1, 5);

        // Queued call, ignored restart, then round-robin back to requester 0.
        clear_counts();
        launch(1'b0, 0, 10, 2);
        repeat (3) tick();
        launch(1'b1, 0, 4, 1);
        check("queued_busy1", req1_busy, 1);
        check("queued_valid1", req1_valid, 0);
        set_req(1'b1, 100, 200, 50);
        tick();
        req1_start = 1'b0;
        wait_done(1'b1, 60, "queued_done1");
        check("queued_done0", done0, 1);
        check("queued_count1", got1, 4);
        check("queued_order", t_done0 < t_first1, 1);

        clear_counts();
        set_req(1'b0, 20, 22, 1);
        push_range(1'b0, 20, 22, 1);
        launch(1'b1, 30, 32, 1);
        wait_done(1'b1, 40, "rr_done1");
        check("rr_done0", done0, 1);
        check("rr_order", t_done0 < t_first1, 1);

        // Backpressure on requester 0.
        clear_counts();
        launch(1'b0, 0, 10, 2);
        n = 0;
        while (done0 < 1 && n < 80) begin
            req0_ready = bp_pat[n % 4];
            tick();
            n++;
        end
        req0_ready = 1'b1;
        check("bp_done0", done0, 1);
        check("bp_count0", got0, 5);

        // Reset in the middle of a stream.
        clear_counts();
        launch(1'b0, 0, 10, 2);
        n = 0;
        while (got0 < 2 && n < 20) begin
            tick();
            n++;
        end
        check("mid_got_before_reset", got0, 2);
        req0_ready = 1'b0;
        _reset = 1'b1;
        exp0.delete();
        tick();
        _reset = 1'b0;
        check("mid_valid0", req0_valid, 0);
        check("mid_out0", req0_out0, 0);
        check("mid_out1", req0_out1, 0);
        check("mid_busy0", req0_busy, 0);
        check("mid_done0", req0_done, 0);
        req0_ready = 1'b1;
        repeat (4) tick();
        check("mid_no_done", done0, 0);
        check("mid_no_more", got0, 2);

        clear_counts();
        launch(1'b0, 0, 6, 2);
        wait_done(1'b0, 20, "post_done0");
        check("post_count0", got0, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
